// File: rtl/jtdd_mcu_pkg.sv
// Address map and decode helper shared by the Double Dragon MCU glue logic.
package jtdd_mcu_pkg;

  localparam logic [15:0] ROM_BASE    = 16'hC000;
  localparam logic [15:0] RAM_START   = 16'h0040;
  localparam logic [15:0] RAM_END     = 16'h013F;
  localparam logic [15:0] SHARED_BASE = 16'h8000;
  localparam logic [15:0] PORT_LIMIT  = 16'h0028;
  localparam logic [5:0]  P6_OFFSET   = 6'h17;

  typedef struct packed {
    logic rom;
    logic ram;
    logic shared;
    logic port;
  } mcu_sel_t;

  // All selects collapse to zero outside valid memory cycles.
  function automatic mcu_sel_t mcu_decode(input logic [15:0] a, input logic vma);
    mcu_sel_t s;
    s.rom    = vma && (a[15:14] == ROM_BASE[15:14]);
    s.ram    = vma && (a >= RAM_START) && (a <= RAM_END);
    s.shared = vma && (a[15:12] == SHARED_BASE[15:12]);
    s.port   = vma && (a < PORT_LIMIT);
    return s;
  endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// True dual-port RAM, registered reads returning old data on read-during-write.
module jtframe_dual_ram #(
  parameter int aw = 9,
  parameter int dw = 8
) (
  input  logic          clk,
  input  logic [aw-1:0] addr0,
  input  logic [dw-1:0] data0,
  input  logic          we0,
  output logic [dw-1:0] q0,
  input  logic [aw-1:0] addr1,
  input  logic [dw-1:0] data1,
  input  logic          we1,
  output logic [dw-1:0] q1
);

  logic [dw-1:0] mem [0:(1<<aw)-1];

  // Port 1 is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    q0 <= mem[addr0];
    q1 <= mem[addr1];
    if (we0) mem[addr0] <= data0;
    if (we1) mem[addr1] <= data1;
  end

endmodule

// File: rtl/jtframe_ff.sv
// Set/clear latch: rising edge of sigedge sets q, level clr forces it low.
module jtframe_ff (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic sigedge,
  output logic q
);

  logic last_reg;

  // The previous value tracks through reset so a level held across reset is not seen as an edge.
  always_ff @(posedge clk) begin
    last_reg <= sigedge;
    if (rst)
      q <= 1'b0;
    else if (clr)
      q <= 1'b0;
    else if (sigedge && !last_reg)
      q <= 1'b1;
  end

endmodule

// File: rtl/jtframe_ram.sv
// Single-port RAM with clock-enabled write and registered read.
module jtframe_ram #(
  parameter int aw = 8,
  parameter int dw = 8
) (
  input  logic          clk,
  input  logic          cen,
  input  logic [aw-1:0] addr,
  input  logic [dw-1:0] data,
  input  logic          we,
  output logic [dw-1:0] q
);

  logic [dw-1:0] mem [0:(1<<aw)-1];

  always_ff @(posedge clk) begin
    if (cen) begin
      q <= mem[addr];
      if (we) mem[addr] <= data;
    end
  end

endmodule

// File: rtl/jtdd_mcu_bus.sv
// Memory, port and interrupt glue between the HD63701 MCU core and the main CPU.
module jtdd_mcu_bus
  import jtdd_mcu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mcu_cen,
  output logic        cpu_cen,
  input  logic [15:0] A,
  input  logic        vma,
  input  logic        rnw,
  input  logic [7:0]  mcu_dout,
  output logic [7:0]  mcu_din,
  input  logic        halted,
  output logic        nmi,
  input  logic        mcu_nmi_set,
  output logic        mcu_irqmain,
  output logic        mcu_ban,
  input  logic [8:0]  cpu_AB,
  input  logic        cpu_wrn,
  input  logic [7:0]  cpu_dout,
  input  logic        com_cs,
  output logic [7:0]  shared_dout,
  output logic [13:0] rom_addr,
  output logic        rom_cs,
  input  logic [7:0]  rom_data,
  input  logic        rom_ok
);

  mcu_sel_t   sel;
  logic       waitn_reg;
  logic [7:0] p6_reg;
  logic [7:0] ram_q;
  logic [7:0] shared_q;
  logic [7:0] port_map [0:31];
  logic [31:0] port_we;
  logic       port_wr;

  assign sel      = mcu_decode(A, vma);
  assign rom_cs   = sel.rom;
  assign rom_addr = A[13:0];
  assign mcu_ban  = vma;
  assign cpu_cen  = mcu_cen & (waitn_reg | rst);
  assign mcu_irqmain = p6_reg[1];

  always_comb begin
    mcu_din = rom_data;
    if (sel.ram)
      mcu_din = ram_q;
    else if (sel.shared)
      mcu_din = shared_q;
    else if (sel.port)
      mcu_din = port_map[A[4:0]];
  end

  // Only five address bits reach the port file, so 0x20-0x27 fold onto 0x00-0x07.
  assign port_wr = sel.port & ~rnw & cpu_cen;

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : gen_port_we
      assign port_we[gi] = port_wr && (A[4:0] == 5'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++)
      if (port_we[i]) port_map[i] <= mcu_dout;
  end

  always_ff @(posedge clk) begin
    if (rst)
      p6_reg <= 8'h00;
    else if (sel.port && !rnw && A[5:0] == P6_OFFSET)
      p6_reg <= mcu_dout;
  end

  // Stall the core while a ROM fetch waits for the SDRAM path.
  always_ff @(posedge clk) begin
    if (rst)
      waitn_reg <= 1'b1;
    else if (sel.rom && !rom_ok)
      waitn_reg <= 1'b0;
    else if (rom_ok)
      waitn_reg <= 1'b1;
  end

  jtframe_ff u_nmi (
    .clk     (clk),
    .rst     (rst),
    .clr     (~p6_reg[0]),
    .sigedge (mcu_nmi_set),
    .q       (nmi)
  );

  jtframe_ram #(.aw(8), .dw(8)) u_iram (
    .clk  (clk),
    .cen  (cpu_cen),
    .addr (A[7:0]),
    .data (mcu_dout),
    .we   (sel.ram & ~rnw),
    .q    (ram_q)
  );

  jtframe_dual_ram #(.aw(9), .dw(8)) u_shared (
    .clk   (clk),
    .addr0 (A[8:0]),
    .data0 (mcu_dout),
    .we0   (sel.shared & ~rnw),
    .q0    (shared_q),
    .addr1 (cpu_AB),
    .data1 (cpu_dout),
    .we1   (~cpu_wrn & com_cs & halted),
    .q1    (shared_dout)
  );

endmodule

// File: tb/tb_jtdd_mcu_bus.sv
// Self-checking bench for jtdd_mcu_bus: directed sequences, a decode table and a randomized model run.
module tb_jtdd_mcu_bus;

  logic        clk = 1'b0;
  logic        rst, mcu_cen, cpu_cen, vma, rnw, halted, nmi, mcu_nmi_set;
  logic        mcu_irqmain, mcu_ban, cpu_wrn, com_cs, rom_cs, rom_ok;
  logic [15:0] A;
  logic [7:0]  mcu_dout, mcu_din, cpu_dout, shared_dout, rom_data;
  logic [8:0]  cpu_AB;
  logic [13:0] rom_addr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  jtdd_mcu_bus dut (
    .clk(clk), .rst(rst), .mcu_cen(mcu_cen), .cpu_cen(cpu_cen), .A(A), .vma(vma),
    .rnw(rnw), .mcu_dout(mcu_dout), .mcu_din(mcu_din), .halted(halted), .nmi(nmi),
    .mcu_nmi_set(mcu_nmi_set), .mcu_irqmain(mcu_irqmain), .mcu_ban(mcu_ban),
    .cpu_AB(cpu_AB), .cpu_wrn(cpu_wrn), .cpu_dout(cpu_dout), .com_cs(com_cs),
    .shared_dout(shared_dout), .rom_addr(rom_addr), .rom_cs(rom_cs),
    .rom_data(rom_data), .rom_ok(rom_ok)
  );

  typedef struct {
    logic [15:0] a;
    logic        vma;
    logic        exp_rom;
    logic [7:0]  exp_din;
  } vec_t;

  vec_t vecs [14];

  // Behavioural model of the three memories and the p6 latch.
  logic [7:0] m_sh [512];
  bit         v_sh [512];
  logic [7:0] m_ir [256];
  bit         v_ir [256];
  logic [7:0] m_pm [32];
  bit         v_pm [32];
  logic [7:0] m_p6;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    vma = 1'b0; rnw = 1'b1; A = 16'h0000;
    cpu_wrn = 1'b1; com_cs = 1'b0; rom_ok = 1'b1;
  endtask

  task automatic mcu_wr(input logic [15:0] a, input logic [7:0] d);
    $display("[TB] mcu write A=%h d=%h cen=%b", a, d, mcu_cen);
    A = a; vma = 1'b1; rnw = 1'b0; mcu_dout = d;
    tick();
    idle();
  endtask

  task automatic mcu_rd(input logic [15:0] a);
    $display("[TB] mcu read  A=%h", a);
    A = a; vma = 1'b1; rnw = 1'b1;
    tick();
  endtask

  task automatic cpu_wr(input logic [8:0] a, input logic [7:0] d, input logic h);
    $display("[TB] cpu write AB=%h d=%h halted=%b", a, d, h);
    cpu_AB = a; cpu_dout = d; cpu_wrn = 1'b0; com_cs = 1'b1; halted = h;
    tick();
    idle();
  endtask

  initial begin
    vecs[0]  = '{16'h0005, 1'b1, 1'b0, 8'h77};
    vecs[1]  = '{16'h0025, 1'b1, 1'b0, 8'h77};
    vecs[2]  = '{16'h0100, 1'b1, 1'b0, 8'hA5};
    vecs[3]  = '{16'h8010, 1'b1, 1'b0, 8'h5A};
    vecs[4]  = '{16'h8210, 1'b1, 1'b0, 8'h5A};
    vecs[5]  = '{16'hC123, 1'b1, 1'b1, 8'hE7};
    vecs[6]  = '{16'hFFFF, 1'b1, 1'b1, 8'hE7};
    vecs[7]  = '{16'hC123, 1'b0, 1'b0, 8'hE7};
    vecs[8]  = '{16'h0100, 1'b0, 1'b0, 8'hE7};
    vecs[9]  = '{16'h0028, 1'b1, 1'b0, 8'hE7};
    vecs[10] = '{16'h003F, 1'b1, 1'b0, 8'hE7};
    vecs[11] = '{16'h0140, 1'b1, 1'b0, 8'hE7};
    vecs[12] = '{16'h9010, 1'b1, 1'b0, 8'hE7};
    vecs[13] = '{16'h7FFF, 1'b1, 1'b0, 8'hE7};

    // Reset
    rst = 1'b1; mcu_cen = 1'b1; halted = 1'b0; mcu_nmi_set = 1'b0;
    cpu_AB = 9'h000; cpu_dout = 8'h00; mcu_dout = 8'h00; rom_data = 8'h00;
    idle();
    repeat (3) tick();
    chk("cen_in_rst", cpu_cen, 1'b1);
    mcu_cen = 1'b0; #1;
    chk("cen_off_in_rst", cpu_cen, 1'b0);
    mcu_cen = 1'b1;
    rst = 1'b0;
    tick();
    chk("rst_nmi", nmi, 1'b0);
    chk("rst_irqmain", mcu_irqmain, 1'b0);
    chk("rst_cen", cpu_cen, 1'b1);

    // p6 and NMI latch
    mcu_wr(16'h0017, 8'h03);
    chk("irqmain_set", mcu_irqmain, 1'b1);
    mcu_nmi_set = 1'b1; #1;
    chk("nmi_before_edge", nmi, 1'b0);
    tick();
    chk("nmi_rise", nmi, 1'b1);
    mcu_wr(16'h0017, 8'h02);
    tick();
    chk("nmi_cleared", nmi, 1'b0);
    chk("irqmain_kept", mcu_irqmain, 1'b1);
    mcu_nmi_set = 1'b0; tick();
    mcu_nmi_set = 1'b1; tick(); tick();
    chk("nmi_blocked", nmi, 1'b0);
    mcu_nmi_set = 1'b0; tick();

    // Shared RAM from the main CPU, gated by halted
    cpu_wr(9'h010, 8'h5A, 1'b1);
    mcu_rd(16'h8010);
    chk("shared_mcu_rd", mcu_din, 8'h5A);
    chk("shared_cpu_rd", shared_dout, 8'h5A);
    cpu_wr(9'h010, 8'h33, 1'b0);
    mcu_rd(16'h8010);
    chk("shared_not_halted", mcu_din, 8'h5A);
    idle();

    // Internal RAM vs port file
    mcu_wr(16'h0000, 8'h11);
    mcu_wr(16'h0100, 8'hA5);
    mcu_rd(16'h0100);
    chk("iram_rd", mcu_din, 8'hA5);
    A = 16'h0000; #1;
    chk("port0_untouched", mcu_din, 8'h11);
    idle();

    // ROM wait state
    A = 16'hC123; vma = 1'b1; rnw = 1'b1; rom_ok = 1'b0; #1;
    chk("rom_cs", rom_cs, 1'b1);
    chk("rom_addr", rom_addr, 14'h0123);
    chk("wait_clk1", cpu_cen, 1'b1);
    tick(); chk("wait_clk2", cpu_cen, 1'b0);
    tick(); chk("wait_clk3", cpu_cen, 1'b0);
    tick(); chk("wait_clk4", cpu_cen, 1'b0);
    rom_ok = 1'b1; #1;
    chk("wait_ok_same", cpu_cen, 1'b0);
    tick(); chk("wait_resume", cpu_cen, 1'b1);
    idle();

    // Port alias and vma gating
    mcu_wr(16'h0025, 8'h77);
    A = 16'h0005; vma = 1'b1; rnw = 1'b1; #1;
    chk("port_alias", mcu_din, 8'h77);
    A = 16'hC000; vma = 1'b0; rom_ok = 1'b0; #1;
    chk("vma0_rom_cs", rom_cs, 1'b0);
    chk("vma0_ban", mcu_ban, 1'b0);
    tick();
    chk("vma0_no_wait", cpu_cen, 1'b1);
    idle();

    // Collision: port 1 wins, then read-during-write returns old data
    A = 16'h8020; vma = 1'b1; rnw = 1'b0; mcu_dout = 8'h11;
    cpu_AB = 9'h020; cpu_dout = 8'h22; cpu_wrn = 1'b0; com_cs = 1'b1; halted = 1'b1;
    $display("[TB] collision write AB=020");
    tick();
    idle();
    mcu_rd(16'h8020);
    chk("collision_mcu", mcu_din, 8'h22);
    chk("collision_cpu", shared_dout, 8'h22);
    idle();
    cpu_wr(9'h020, 8'h44, 1'b1);
    chk("rdw_old", shared_dout, 8'h22);
    tick();
    chk("rdw_new", shared_dout, 8'h44);

    // Decode table
    rom_data = 8'hE7;
    for (int i = 0; i < 14; i++) begin
      logic [15:0] a;
      a = vecs[i].a;
      A = a; vma = vecs[i].vma; rnw = 1'b1; rom_ok = 1'b1;
      $display("[TB] vector %0d A=%h vma=%b", i, a, vecs[i].vma);
      tick();
      chk($sformatf("vec%0d_rom_cs", i), rom_cs, vecs[i].exp_rom);
      chk($sformatf("vec%0d_rom_addr", i), rom_addr, a[13:0]);
      chk($sformatf("vec%0d_ban", i), mcu_ban, vecs[i].vma);
      chk($sformatf("vec%0d_din", i), mcu_din, vecs[i].exp_din);
    end
    idle();

    // Randomized run against the model
    for (int i = 0; i < 512; i++) v_sh[i] = 1'b0;
    for (int i = 0; i < 256; i++) v_ir[i] = 1'b0;
    for (int i = 0; i < 32; i++) v_pm[i] = 1'b0;
    mcu_wr(16'h0017, 8'h02);
    m_p6 = 8'h02;
    for (int t = 0; t < 250; t++) begin
      int op, reg_sel;
      logic [15:0] a;
      logic [7:0]  d;
      logic [8:0]  ab;
      logic        h, cen;
      op = $urandom_range(0, 4);
      reg_sel = $urandom_range(0, 2);
      d = 8'($urandom);
      case (reg_sel)
        0: a = 16'h0040 + 16'($urandom_range(0, 255));
        1: a = {4'h8, 12'($urandom)};
        default: a = 16'($urandom_range(0, 39));
      endcase
      case (op)
        0: begin
          cen = ($urandom_range(0, 3) != 0);
          mcu_cen = cen;
          mcu_wr(a, d);
          mcu_cen = 1'b1;
          if (reg_sel == 0 && cen) begin m_ir[a[7:0]] = d; v_ir[a[7:0]] = 1'b1; end
          if (reg_sel == 1) begin m_sh[a[8:0]] = d; v_sh[a[8:0]] = 1'b1; end
          if (reg_sel == 2) begin
            if (cen) begin m_pm[a[4:0]] = d; v_pm[a[4:0]] = 1'b1; end
            if (a == 16'h0017) m_p6 = d;
          end
          chk("rnd_irqmain", mcu_irqmain, m_p6[1]);
        end
        1: begin
          ab = 9'($urandom);
          h = 1'($urandom);
          cpu_wr(ab, d, h);
          if (h) begin m_sh[ab] = d; v_sh[ab] = 1'b1; end
        end
        2: begin
          mcu_rd(a);
          if (reg_sel == 0 && v_ir[a[7:0]]) chk("rnd_iram", mcu_din, m_ir[a[7:0]]);
          if (reg_sel == 1 && v_sh[a[8:0]]) chk("rnd_shared", mcu_din, m_sh[a[8:0]]);
          if (reg_sel == 2 && v_pm[a[4:0]]) chk("rnd_port", mcu_din, m_pm[a[4:0]]);
          idle();
        end
        3: begin
          ab = 9'($urandom);
          cpu_AB = ab;
          $display("[TB] cpu read  AB=%h", ab);
          tick();
          if (v_sh[ab]) chk("rnd_cpu_rd", shared_dout, m_sh[ab]);
        end
        default: begin
          a = {2'b11, 14'($urandom)};
          rom_data = d;
          A = a; vma = 1'b1; rnw = 1'b1; rom_ok = 1'b1; #1;
          $display("[TB] rom read  A=%h", a);
          chk("rnd_rom_din", mcu_din, d);
          chk("rnd_rom_addr", rom_addr, a[13:0]);
          tick();
          chk("rnd_rom_cen", cpu_cen, 1'b1);
          idle();
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
